mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, the number of valid byte-address bits; any set bit at or above ADDR_W is out of range.
REQ-002 SHALL have parameter READ_LATENCY, default 1, legal 1..3, the memory read latency in cycles.
REQ-003 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  1  request offered by the pipeline.
REQ-006 req_ready_o  out  1  unit can accept a request.
REQ-007 req_we_i  in  1  1 = store, 0 = load.
REQ-008 req_size_i  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 req_unsigned_i  in  1  1 = zero-extend a load, 0 = sign-extend.
REQ-010 req_addr_i  in  32  byte address.
REQ-011 req_wdata_i  in  32  store data, LSB-justified.
REQ-012 rsp_valid_o  out  1  response available.
REQ-013 rsp_ready_i  in  1  consumer takes the response.
REQ-014 rsp_rdata_o  out  32  load result; 0 for stores and errors.
REQ-015 rsp_err_o  out  1  request was misaligned, illegal or out of range.
REQ-016 mem_address_o  out  32  address to the data memory manager.
REQ-017 mem_data_o  out  32  lane-positioned store data.
REQ-018 mem_wren_o  out  1  write enable to memory.
REQ-019 mem_byte_mode_o  out  32  {30'b0, size}.
REQ-020 mem_data_i  in  32  aligned word read from memory.

Function
REQ-021 FSM states: IDLE, WRITE, READ, RESP.
REQ-022 req_ready_o SHALL be 1 only in IDLE.
REQ-023 A request is accepted on an edge where req_valid_i and req_ready_o are both 1; its fields are registered on that edge.
REQ-024 Error conditions: size 11; halfword with addr[0]=1; word with addr[1:0]!=0; out-of-range address.
REQ-025 An erroring request SHALL go IDLE->RESP with rsp_err_o=1 and rsp_rdata_o=0, and SHALL cause no mem_wren_o pulse.
REQ-026 Store accepted at cycle T:
- WRITE during T+1, with mem_wren_o=1 for exactly that cycle.
- mem_data_o = wdata shifted left by 8*addr[1:0].
- RESP from T+2.
REQ-027 Load accepted at T:
- mem_address_o is valid from T+1.
- READ lasts READ_LATENCY+1 cycles, tracked by a down-counter.
- mem_data_i is captured on the edge ending cycle T+1+READ_LATENCY.
- RESP from T+2+READ_LATENCY.
REQ-028 Load extraction, little-endian:
- byte lane = addr[1:0]; halfword lane = addr[1].
- The result is extended to 32 bits per req_unsigned_i.
REQ-029 mem_address_o, mem_data_o and mem_byte_mode_o SHALL hold their values from WRITE/READ entry until the next accept.
REQ-030 mem_wren_o SHALL be 0 in every state except WRITE.
REQ-031 RESP handshake:
- rsp_valid_o=1 in RESP; rsp_rdata_o and rsp_err_o are stable while rsp_valid_o=1 and rsp_ready_i=0.
- On an edge with rsp_ready_i=1: RESP->IDLE, and rsp_valid_o drops the next cycle.
REQ-032 No accept SHALL occur in the cycle RESP exits; back-to-back throughput is one request per 3 cycles (stores) or 3+READ_LATENCY cycles (loads).
REQ-033 A store of size word SHALL pass all 32 bits unshifted.
REQ-034 Halfword at addr[1]=1 SHALL use bits [31:16].
REQ-035 Address bits ADDR_W-1..0 SHALL be forwarded unchanged on mem_address_o.

Reset
REQ-036 RST=0 SHALL immediately, independent of CLK:
- put the FSM in IDLE;
- force mem_wren_o=0, rsp_valid_o=0, rsp_err_o=0;
- clear rsp_rdata_o, mem_address_o, mem_data_o, mem_byte_mode_o and the latency counter to 0.
REQ-037 req_ready_o SHALL be 0 while RST=0 and 1 on the first cycle after release.
REQ-038 Reset asserted during WRITE or READ SHALL abandon the transaction and produce no response.

Verification
REQ-039 Store byte 0xA5 to 0x00000003 -> mem_wren_o high one cycle at T+1, mem_data_o=0xA5000000, mem_byte_mode_o=0, rsp_err_o=0 at T+2.
REQ-040 Load halfword, signed, at 0x00000002 with mem_data_i=0x8001_1234 -> rsp_rdata_o=0xFFFF8001 at T+3 (READ_LATENCY=1).
REQ-041 Load word at 0x00000006 -> rsp_err_o=1, rsp_rdata_o=0, no memory write, response at T+1.
REQ-042 Load byte, unsigned, at 0x00000001 with mem_data_i=0x0000F000, rsp_ready_i held 0 for 5 cycles -> rsp_rdata_o=0x000000F0 held stable; req_ready_o=0 throughout.
REQ-043 RST pulsed low during READ -> rsp_valid_o stays 0, req_ready_o=1 after release, a subsequent store completes normally.
REQ-044 Load at 0x00100000 (ADDR_W=20) -> rsp_err_o=1, no memory write.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between pipeline and data memory manager
module mem_access_unit #(
  parameter int ADDR_W       = 20,
  parameter int READ_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  output logic        mem_wren_o,
  output logic [31:0] mem_byte_mode_o,
  input  logic [31:0] mem_data_i
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [1:0]  r_size;
  logic        r_uns;
  logic        r_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;

  logic        w_accept;
  logic        w_err;
  logic        w_oor;
  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_shamt  = {req_addr_i[1:0], 3'b000};
  assign w_oor    = |(req_addr_i >> ADDR_W);
  assign w_err    = (req_size_i == 2'b11) ||
                    (req_size_i == 2'b01 && req_addr_i[0]) ||
                    (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00) ||
                    w_oor;

  // Ready is gated by reset so the pipeline sees a busy unit while reset is held.
  assign req_ready_o = (r_state == IDLE) && RST;
  assign w_accept    = req_valid_i && req_ready_o;

  assign rsp_valid_o     = (r_state == RESP);
  assign mem_wren_o      = (r_state == WRITE);
  assign rsp_rdata_o     = r_rdata;
  assign rsp_err_o       = r_err;
  assign mem_address_o   = r_addr;
  assign mem_data_o      = r_wdata;
  assign mem_byte_mode_o = {30'b0, r_size};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_err ? RESP : (req_we_i ? WRITE : READ);
      WRITE:   w_next = RESP;
      READ:    if (r_cnt == 2'd0) w_next = RESP;
      RESP:    if (rsp_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Little-endian lane selection from the aligned memory word.
  always_comb begin
    w_shifted = mem_data_i >> {r_addr[1:0], 3'b000};
    w_half    = r_addr[1] ? mem_data_i[31:16] : mem_data_i[15:0];
    case (r_size)
      2'b00:   w_load = {{24{~r_uns & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{16{~r_uns & w_half[15]}}, w_half};
      default: w_load = mem_data_i;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cnt   <= 2'd0;
      r_size  <= 2'd0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else if (w_accept) begin
      r_cnt   <= LAT;
      r_size  <= req_size_i;
      r_uns   <= req_unsigned_i;
      r_err   <= w_err;
      r_addr  <= req_addr_i;
      r_wdata <= req_wdata_i << w_shamt;
      r_rdata <= 32'd0;
    end else if (r_state == READ) begin
      if (r_cnt == 2'd0) r_rdata <= w_load;
      else               r_cnt   <= r_cnt - 2'd1;
    end else if (r_state == RESP && rsp_ready_i) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end
  end

endmodule
